local_packet_receiver: RTL

Reassembles the 4-bit flit stream delivered by the router's local output port into 32-bit spike packets for the attached neuron. It is the inverse of the local injection path, where the neuron hands a 32-bit packet to the router and the router serialises it. The block sits inside the neuron cell between router local output and neuron input. It drives the router's local-neuron back-pressure signal and buffers completed packets until the neuron consumes them.

---
 rtl/noc_pkg.sv | 16 +
 rtl/packet_fifo.sv | 51 +++++
 rtl/local_packet_receiver.sv | 82 ++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC types and sizing for the neuron-side injection and receive paths.
// No logic; constants and typedefs only.
// Packet width is an integer multiple of the flit width.
package noc_pkg;
   localparam int PACKET_SIZE      = 32;
   localparam int FLIT_SIZE        = 4;
   localparam int FLITS_PER_PACKET = PACKET_SIZE / FLIT_SIZE;

   typedef logic [FLIT_SIZE-1:0]   flit_t;
   typedef logic [PACKET_SIZE-1:0] packet_t;

   typedef enum logic {
      RX_IDLE,
      RX_RECV
   } rx_state_t;
endpackage

// File: rtl/packet_fifo.sv
// Synchronous FIFO holding completed packets; head is read straight from storage.
// Latency: a push is visible at the head in the cycle after the edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
module packet_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_dat = mem[rd_ptr];
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/local_packet_receiver.sv
// Reassembles MSB-first flits from the router local port into packets for the neuron.
// Latency: packet at the buffer head one cycle after its last flit is accepted.
// Backpressure: full asserts from registered occupancy; held flits are never sampled.
module local_packet_receiver
   import noc_pkg::*;
#(
   parameter int PACKET_SIZE = noc_pkg::PACKET_SIZE,
   parameter int FLIT_SIZE   = noc_pkg::FLIT_SIZE,
   parameter int PKT_DEPTH   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [FLIT_SIZE-1:0]   flit_in,
   input  logic                   write_req,
   output logic                   full,
   output logic [PACKET_SIZE-1:0] pkt_data,
   output logic                   pkt_valid,
   input  logic                   pkt_ready,
   output logic [15:0]            rx_count
);
   localparam int FLITS   = PACKET_SIZE / FLIT_SIZE;
   localparam int CNT_W   = $clog2(FLITS);
   localparam int FIFO_CW = $clog2(PKT_DEPTH + 1);
   localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(FLITS - 1);

   rx_state_t              state;
   logic [CNT_W-1:0]       flit_cnt;
   logic [PACKET_SIZE-1:0] shreg;
   logic [15:0]            rx_cnt_q;
   logic [PACKET_SIZE-1:0] asm_word;
   logic [FIFO_CW-1:0]     fifo_count;
   logic                   fifo_empty;
   logic                   accept;
   logic                   pkt_push;
   logic                   pkt_pop;

   assign accept    = write_req && !full;
   assign asm_word  = {shreg[PACKET_SIZE-FLIT_SIZE-1:0], flit_in};
   assign pkt_push  = accept && (state == RX_RECV) && (flit_cnt == LAST_FLIT);
   assign pkt_pop   = pkt_valid && pkt_ready;
   assign pkt_valid = !fifo_empty;
   assign rx_count  = rx_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RX_IDLE;
         flit_cnt <= '0;
         shreg    <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (accept) begin
            shreg <= asm_word;
            if (flit_cnt == LAST_FLIT) begin
               flit_cnt <= '0;
               state    <= RX_IDLE;
            end else begin
               flit_cnt <= flit_cnt + 1'b1;
               state    <= RX_RECV;
            end
         end
         if (pkt_push) rx_cnt_q <= rx_cnt_q + 16'd1;
      end
   end

   packet_fifo #(
      .WIDTH (PACKET_SIZE),
      .DEPTH (PKT_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (pkt_push),
      .push_dat (asm_word),
      .pop      (pkt_pop),
      .head_dat (pkt_data),
      .count    (fifo_count),
      .full     (full),
      .empty    (fifo_empty)
   );

   // Push is gated by full, so occupancy can never exceed the buffer depth.
   assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= FIFO_CW'(PKT_DEPTH));
endmodule
